// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the gated-clock enable sequencer.
package clk_gate_pkg;

   localparam int WAKE_CNT_W = 16;

   typedef enum logic [1:0] {
      CG_OFF  = 2'd0,
      CG_WAKE = 2'd1,
      CG_ON   = 2'd2,
      CG_IDLE = 2'd3
   } cg_state_e;

endpackage

// File: rtl/clk_gate_timer.sv
// Loadable down-counter shared by the wake settle and idle hold-off phases.
// Decrement stops at zero, so the count can never wrap.
module clk_gate_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_r;

   // Counter register: load has priority over decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign value = cnt_r;
   assign zero  = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable sequencer for a BUFGCE-style gated clock buffer: wakes on demand,
// acknowledges once the clock has settled, and drops CE after an idle hold-off.
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 16,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_i,
   output logic [NUM_REQ-1:0]    ack_o,
   input  logic                  force_on_i,
   input  logic                  gate_en_i,
   output logic                  ce_o,
   output logic                  clk_on_o,
   output logic [1:0]            state_o,
   output logic [WAKE_CNT_W-1:0] wake_cnt_o
);

   localparam bit WAKE_BYPASS = (WAKE_CYCLES == 32'sd0);
   localparam bit IDLE_BYPASS = (IDLE_CYCLES == 32'sd0);
   localparam logic [CNT_W-1:0] WAKE_LOAD =
      WAKE_BYPASS ? {CNT_W{1'b0}} : CNT_W'(WAKE_CYCLES - 32'sd1);
   localparam logic [CNT_W-1:0] IDLE_LOAD =
      IDLE_BYPASS ? {CNT_W{1'b0}} : CNT_W'(IDLE_CYCLES - 32'sd1);

   cg_state_e             state_r;
   logic                  ce_r;
   logic                  clk_on_r;
   logic [WAKE_CNT_W-1:0] wake_cnt_r;

   logic                  demand_s;
   logic                  timer_load_s;
   logic [CNT_W-1:0]      timer_load_val_s;
   logic                  timer_dec_s;
   logic [CNT_W-1:0]      timer_val_s;
   logic                  timer_zero_s;
   logic                  timer_nonzero_s;

   assign demand_s        = (|req_i) | force_on_i | ~gate_en_i;
   assign timer_nonzero_s = (timer_val_s != {CNT_W{1'b0}});

   // Timer control: load on phase entry, count down only while the phase runs.
   always_comb begin
      timer_load_s     = 1'b0;
      timer_load_val_s = {CNT_W{1'b0}};
      timer_dec_s      = 1'b0;
      case (state_r)
         CG_OFF: begin
            if (demand_s && !WAKE_BYPASS) begin
               timer_load_s     = 1'b1;
               timer_load_val_s = WAKE_LOAD;
            end else begin
               timer_load_s     = 1'b0;
            end
         end
         CG_WAKE: begin
            timer_dec_s = timer_nonzero_s;
         end
         CG_ON: begin
            if (!demand_s && !IDLE_BYPASS) begin
               timer_load_s     = 1'b1;
               timer_load_val_s = IDLE_LOAD;
            end else begin
               timer_load_s     = 1'b0;
            end
         end
         CG_IDLE: begin
            if (!demand_s) begin
               timer_dec_s = timer_nonzero_s;
            end else begin
               timer_dec_s = 1'b0;
            end
         end
         default: begin
            timer_dec_s = 1'b0;
         end
      endcase
   end

   clk_gate_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load_s),
      .load_val (timer_load_val_s),
      .dec      (timer_dec_s),
      .value    (timer_val_s),
      .zero     (timer_zero_s)
   );

   // Sequencer FSM with registered CE, status and wake statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= CG_OFF;
         ce_r       <= 1'b0;
         clk_on_r   <= 1'b0;
         wake_cnt_r <= {WAKE_CNT_W{1'b0}};
      end else begin
         case (state_r)
            CG_OFF: begin
               if (demand_s) begin
                  ce_r <= 1'b1;
                  if (wake_cnt_r != {WAKE_CNT_W{1'b1}}) begin
                     wake_cnt_r <= wake_cnt_r + WAKE_CNT_W'(1);
                  end
                  if (WAKE_BYPASS) begin
                     state_r  <= CG_ON;
                     clk_on_r <= 1'b1;
                  end else begin
                     state_r  <= CG_WAKE;
                     clk_on_r <= 1'b0;
                  end
               end else begin
                  ce_r     <= 1'b0;
                  clk_on_r <= 1'b0;
               end
            end
            CG_WAKE: begin
               // Runs to completion even if demand goes away: minimum CE high time.
               ce_r <= 1'b1;
               if (timer_zero_s) begin
                  state_r  <= CG_ON;
                  clk_on_r <= 1'b1;
               end else begin
                  clk_on_r <= 1'b0;
               end
            end
            CG_ON: begin
               if (!demand_s && IDLE_BYPASS) begin
                  state_r  <= CG_OFF;
                  ce_r     <= 1'b0;
                  clk_on_r <= 1'b0;
               end else if (!demand_s) begin
                  state_r  <= CG_IDLE;
                  ce_r     <= 1'b1;
                  clk_on_r <= 1'b1;
               end else begin
                  ce_r     <= 1'b1;
                  clk_on_r <= 1'b1;
               end
            end
            CG_IDLE: begin
               if (demand_s) begin
                  state_r  <= CG_ON;
                  ce_r     <= 1'b1;
                  clk_on_r <= 1'b1;
               end else if (timer_zero_s) begin
                  state_r  <= CG_OFF;
                  ce_r     <= 1'b0;
                  clk_on_r <= 1'b0;
               end else begin
                  ce_r     <= 1'b1;
                  clk_on_r <= 1'b1;
               end
            end
            default: begin
               state_r  <= CG_OFF;
               ce_r     <= 1'b0;
               clk_on_r <= 1'b0;
            end
         endcase
      end
   end

   assign ce_o       = ce_r;
   assign clk_on_o   = clk_on_r;
   assign state_o    = state_r;
   assign wake_cnt_o = wake_cnt_r;
   assign ack_o      = req_i & {NUM_REQ{clk_on_r}};

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: default-parameter instance plus a
// zero-wake/zero-idle instance for the bypass paths.
module tb_clk_gate_ctrl;
   import clk_gate_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s, force_on_s, gate_en_s;
   logic [3:0]  req_s, ack_s;
   logic        ce_s, clk_on_s;
   logic [1:0]  state_s;
   logic [15:0] wcnt_s;

   logic        f_rst_s, f_force_s, f_gate_s;
   logic [3:0]  f_req_s, f_ack_s;
   logic        f_ce_s, f_clk_on_s;
   logic [1:0]  f_state_s;
   logic [15:0] f_wcnt_s;

   int n_vec = 0;
   int n_err = 0;

   clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(2), .IDLE_CYCLES(16), .CNT_W(8)) dut (
      .clk(clk), .rst(rst_s), .req_i(req_s), .ack_o(ack_s), .force_on_i(force_on_s),
      .gate_en_i(gate_en_s), .ce_o(ce_s), .clk_on_o(clk_on_s), .state_o(state_s),
      .wake_cnt_o(wcnt_s)
   );

   clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(0), .IDLE_CYCLES(0), .CNT_W(8)) u_fast (
      .clk(clk), .rst(f_rst_s), .req_i(f_req_s), .ack_o(f_ack_s), .force_on_i(f_force_s),
      .gate_en_i(f_gate_s), .ce_o(f_ce_s), .clk_on_o(f_clk_on_s), .state_o(f_state_s),
      .wake_cnt_o(f_wcnt_s)
   );

   typedef struct {
      logic [3:0]  req;
      logic        force_on;
      logic        gate_en;
      logic [1:0]  st;
      logic        ce;
      logic        clk_on;
      logic [3:0]  ack;
      logic [15:0] wcnt;
   } vec_t;

   vec_t vecs [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_st;

      //          req      frc   gen   state      ce    on    ack      wcnt
      vecs[0]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 16'd0};
      vecs[1]  = '{4'b0001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 16'd1};
      vecs[2]  = '{4'b0001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 16'd1};
      vecs[3]  = '{4'b0001, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0001, 16'd1};
      vecs[4]  = '{4'b0011, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0011, 16'd1};
      vecs[5]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 4'b0000, 16'd1};
      vecs[6]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 4'b0000, 16'd1};
      vecs[7]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0100, 16'd1};
      vecs[8]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0000, 16'd1};
      vecs[9]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 4'b0000, 16'd1};
      vecs[10] = '{4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 4'b0000, 16'd1};

      rst_s = 1'b1; req_s = 4'b1111; force_on_s = 1'b0; gate_en_s = 1'b1;
      f_rst_s = 1'b1; f_req_s = 4'b0000; f_force_s = 1'b0; f_gate_s = 1'b1;
      tick();
      tick();
      chk("reset state", 32'(state_s), 32'(CG_OFF));
      chk("reset ce", 32'(ce_s), 32'd0);
      chk("reset clk_on", 32'(clk_on_s), 32'd0);
      chk("reset ack", 32'(ack_s), 32'd0);
      chk("reset wake_cnt", 32'(wcnt_s), 32'd0);

      rst_s = 1'b0; f_rst_s = 1'b0; req_s = 4'b0000;
      for (int i = 0; i < 11; i++) begin
         req_s = vecs[i].req; force_on_s = vecs[i].force_on; gate_en_s = vecs[i].gate_en;
         tick();
         chk($sformatf("v%0d state", i), 32'(state_s), 32'(vecs[i].st));
         chk($sformatf("v%0d ce", i), 32'(ce_s), 32'(vecs[i].ce));
         chk($sformatf("v%0d clk_on", i), 32'(clk_on_s), 32'(vecs[i].clk_on));
         chk($sformatf("v%0d ack", i), 32'(ack_s), 32'(vecs[i].ack));
         chk($sformatf("v%0d wake_cnt", i), 32'(wcnt_s), 32'(vecs[i].wcnt));
      end

      // Idle hold-off: 15 more cycles in IDLE with CE high, then OFF.
      for (int k = 0; k < 15; k++) begin
         tick();
         chk($sformatf("idle hold %0d state", k), 32'(state_s), 32'(CG_IDLE));
         chk($sformatf("idle hold %0d ce", k), 32'(ce_s), 32'd1);
      end
      tick();
      chk("idle expiry state", 32'(state_s), 32'(CG_OFF));
      chk("idle expiry ce", 32'(ce_s), 32'd0);
      chk("idle expiry clk_on", 32'(clk_on_s), 32'd0);

      // Request arriving in IDLE with timer at 5 is acked at once.
      req_s = 4'b0001;
      tick(); tick(); tick();
      chk("rewake state", 32'(state_s), 32'(CG_ON));
      chk("rewake wake_cnt", 32'(wcnt_s), 32'd2);
      req_s = 4'b0000;
      tick();
      for (int k = 0; k < 10; k++) tick();
      chk("idle mid state", 32'(state_s), 32'(CG_IDLE));
      req_s = 4'b0100;
      #1;
      chk("idle same-cycle ack", 32'(ack_s), 32'b0100);
      tick();
      chk("idle return state", 32'(state_s), 32'(CG_ON));
      chk("idle return wake_cnt", 32'(wcnt_s), 32'd2);

      // Back to OFF, then a single-cycle pulse on req[1].
      req_s = 4'b0000;
      for (int k = 0; k < 17; k++) tick();
      chk("pre-pulse state", 32'(state_s), 32'(CG_OFF));
      req_s = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i < 2) exp_st = 2'd1;
         else if (i < 3) exp_st = 2'd2;
         else if (i < 19) exp_st = 2'd3;
         else exp_st = 2'd0;
         chk($sformatf("pulse c%0d state", i), 32'(state_s), 32'(exp_st));
         chk($sformatf("pulse c%0d ack", i), 32'(ack_s), 32'd0);
         req_s = 4'b0000;
      end
      chk("pulse wake_cnt", 32'(wcnt_s), 32'd3);

      // Reset during WAKE and during IDLE.
      req_s = 4'b0001;
      tick();
      chk("pre-rst wake state", 32'(state_s), 32'(CG_WAKE));
      rst_s = 1'b1;
      tick();
      chk("rst in wake state", 32'(state_s), 32'(CG_OFF));
      chk("rst in wake ce", 32'(ce_s), 32'd0);
      chk("rst in wake ack", 32'(ack_s), 32'd0);
      chk("rst in wake wake_cnt", 32'(wcnt_s), 32'd0);
      rst_s = 1'b0;
      tick(); tick(); tick();
      chk("post-rst on state", 32'(state_s), 32'(CG_ON));
      chk("post-rst wake_cnt", 32'(wcnt_s), 32'd1);
      req_s = 4'b0000;
      tick();
      chk("pre-rst idle state", 32'(state_s), 32'(CG_IDLE));
      rst_s = 1'b1;
      tick();
      chk("rst in idle state", 32'(state_s), 32'(CG_OFF));
      chk("rst in idle ce", 32'(ce_s), 32'd0);
      chk("rst in idle clk_on", 32'(clk_on_s), 32'd0);
      chk("rst in idle wake_cnt", 32'(wcnt_s), 32'd0);
      rst_s = 1'b0;

      // Bypass instance: CE follows demand one edge late.
      f_req_s = 4'b0001;
      tick();
      chk("fast on1 state", 32'(f_state_s), 32'(CG_ON));
      chk("fast on1 ce", 32'(f_ce_s), 32'd1);
      chk("fast on1 ack", 32'(f_ack_s), 32'b0001);
      f_req_s = 4'b0000;
      tick();
      chk("fast off1 state", 32'(f_state_s), 32'(CG_OFF));
      chk("fast off1 ce", 32'(f_ce_s), 32'd0);
      f_req_s = 4'b0001;
      tick();
      chk("fast on2 ce", 32'(f_ce_s), 32'd1);
      chk("fast on2 wake_cnt", 32'(f_wcnt_s), 32'd2);
      f_req_s = 4'b0000;
      tick();
      chk("fast off2 ce", 32'(f_ce_s), 32'd0);
      f_gate_s = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("fast gate_en=0 c%0d ce", k), 32'(f_ce_s), 32'd1);
         chk($sformatf("fast gate_en=0 c%0d state", k), 32'(f_state_s), 32'(CG_ON));
      end
      chk("fast gate_en=0 wake_cnt", 32'(f_wcnt_s), 32'd3);
      f_gate_s = 1'b1;
      tick();
      chk("fast gate restore ce", 32'(f_ce_s), 32'd0);

      // Saturation of the wake counter.
      force u_fast.wake_cnt_r = 16'hFFFE;
      #1;
      release u_fast.wake_cnt_r;
      f_req_s = 4'b0001;
      tick();
      chk("sat first wake_cnt", 32'(f_wcnt_s), 32'h0000FFFF);
      f_req_s = 4'b0000;
      tick();
      f_req_s = 4'b0001;
      tick();
      chk("sat hold wake_cnt", 32'(f_wcnt_s), 32'h0000FFFF);
      f_req_s = 4'b0000;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
